serial2tcp_line_echo: RTL and testbench
=======================================

Name: serial2tcp_line_echo

Overview:
- Line-buffered echo responder on the serial2tcp byte-stream interface.
- Accepts bytes from the TCP side on the sink stream and stores them until a line terminator arrives.
- Then sends the stored line back on the source stream followed by CR LF, and returns to receiving.
- Used as a simulation endpoint for the serial2tcp bridge, with real buffering and back-pressure, replacing the pass-through wire.

Parameters:
- DEPTH, 64: line buffer capacity in bytes; must be a power of two, at least 2.
- TERM, 8'h0A: byte value that ends a line.

Ports:
- sys_clk  input  1: single clock; all logic on its rising edge.
- sys_rst  input  1: asynchronous, active-high reset.
- serial2tcp_sink_valid  input  1: incoming byte valid.
- serial2tcp_sink_ready  output  1: block can accept an incoming byte.
- serial2tcp_sink_data  input  8: incoming byte.
- serial2tcp_source_valid  output  1: outgoing byte valid.
- serial2tcp_source_ready  input  1: downstream accepts the outgoing byte.
- serial2tcp_source_data  output  8: outgoing byte.
- overflow  output  1: sticky flag; at least one byte was dropped in the current line.
- lines_done  output  16: count of fully echoed lines; wraps 0xFFFF->0.

Behaviour:
- Transfer rule: a transfer occurs on a clock edge where valid and ready are both 1.
- Reset values:
  - state=RECV, count=0, rd_idx=0.
  - serial2tcp_source_valid=0, serial2tcp_source_data=0.
  - serial2tcp_sink_ready=1, overflow=0, lines_done=0.
  - Buffer contents are don't-care.
- Reset mid-operation: an in-flight line is discarded and source_valid drops immediately. No partial CR/LF is emitted after reset.
- States: RECV, SEND, SEND_CR, SEND_LF.
- RECV:
  - sink_ready=1, source_valid=0. On each sink transfer:
  - byte==TERM and count>0: next state SEND; load output register with buf[0], rd_idx=1.
  - byte==TERM and count==0: next state SEND_CR (empty line echoes CR LF only).
  - byte==8'h0D: discarded; no store, no count change.
  - any other byte, count<DEPTH: buf[count]<=byte, count+=1.
  - any other byte, count==DEPTH: byte dropped, overflow<=1.
- SEND, SEND_CR, SEND_LF:
  - sink_ready=0, source_valid=1.
  - source_data comes from a registered output, stable while valid and not ready.
- SEND: on a source transfer, if rd_idx==count go to SEND_CR with data=8'h0D; else data<=buf[rd_idx], rd_idx+=1.
- SEND_CR: on a source transfer, go to SEND_LF with data=8'h0A.
- SEND_LF: on a source transfer, go to RECV; count=0, rd_idx=0, overflow<=0, lines_done+=1.
- Latency:
  - The first echoed byte is valid the cycle after the TERM transfer.
  - With ready held at 1, one output byte per cycle: count+2 cycles from first byte to return to RECV.
- Back-pressure: source_ready low holds state, data and valid unchanged for any duration.
- Width rules: count is $clog2(DEPTH)+1 bits so it can hold DEPTH; rd_idx has the same width.
- Simultaneity: sink and source are never active in the same cycle, so no simultaneous read and write of the buffer.

Test Plan:
- Reset, then send "AB\n" with source_ready=1: source emits 0x41,0x42,0x0D,0x0A on 4 consecutive cycles starting the cycle after '\n'; lines_done=1; sink_ready back to 1 the cycle after LF transfers.
- Send "hi\r\n": CR is dropped; output is 0x68,0x69,0x0D,0x0A.
- Send "\n" alone: output is 0x0D,0x0A only; lines_done increments.
- With DEPTH=4, send "ABCDEF\n": overflow=1 after 'E'; output is A,B,C,D,CR,LF; overflow clears after LF transfers.
- Send "XYZ\n", then toggle source_ready in a 1-on/2-off pattern: each byte is held stable until accepted, no byte is duplicated or lost, and sink_ready stays 0 until LF transfers.
- Assert sys_rst during SEND after 1 byte: source_valid goes 0 immediately; after reset, "Q\n" echoes exactly Q,CR,LF and lines_done=1.

Source files
------------

// File: rtl/serial2tcp_line_echo.sv
// rtl/serial2tcp_line_echo.sv - line-buffered echo responder for the serial2tcp byte stream
// Collects a line from the sink stream, then replays it on the source stream followed by CR LF.
module serial2tcp_line_echo #(
    parameter int         DEPTH = 64,
    parameter logic [7:0] TERM  = 8'h0A
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        serial2tcp_sink_valid,
    output logic        serial2tcp_sink_ready,
    input  logic [7:0]  serial2tcp_sink_data,
    output logic        serial2tcp_source_valid,
    input  logic        serial2tcp_source_ready,
    output logic [7:0]  serial2tcp_source_data,
    output logic        overflow,
    output logic [15:0] lines_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {RECV, SEND, SEND_CR, SEND_LF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    data_q, data_d;
    logic          src_valid_q, src_valid_d;
    logic          snk_ready_q, snk_ready_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   lines_done_q, lines_done_d;
    logic          wr_en;
    logic          sink_fire;
    logic          src_fire;

    logic [7:0] line_buf [DEPTH];

    assign sink_fire = serial2tcp_sink_valid && snk_ready_q;
    assign src_fire  = src_valid_q && serial2tcp_source_ready;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_idx_d     = rd_idx_q;
        data_d       = data_q;
        src_valid_d  = src_valid_q;
        snk_ready_d  = snk_ready_q;
        overflow_d   = overflow_q;
        lines_done_d = lines_done_q;
        wr_en        = 1'b0;
        unique case (state_q)
            RECV: begin
                if (sink_fire) begin
                    if (serial2tcp_sink_data == TERM) begin
                        src_valid_d = 1'b1;
                        snk_ready_d = 1'b0;
                        if (count_q != '0) begin
                            state_d  = SEND;
                            data_d   = line_buf[0];
                            rd_idx_d = CW'(1);
                        end else begin
                            state_d = SEND_CR;
                            data_d  = 8'h0D;
                        end
                    end else if (serial2tcp_sink_data != 8'h0D) begin
                        if (count_q < DEPTH_C) begin
                            wr_en   = 1'b1;
                            count_d = count_q + CW'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            SEND: begin
                if (src_fire) begin
                    if (rd_idx_q == count_q) begin
                        state_d = SEND_CR;
                        data_d  = 8'h0D;
                    end else begin
                        data_d   = line_buf[rd_idx_q[AW-1:0]];
                        rd_idx_d = rd_idx_q + CW'(1);
                    end
                end
            end
            SEND_CR: begin
                if (src_fire) begin
                    state_d = SEND_LF;
                    data_d  = 8'h0A;
                end
            end
            SEND_LF: begin
                if (src_fire) begin
                    state_d      = RECV;
                    count_d      = '0;
                    rd_idx_d     = '0;
                    overflow_d   = 1'b0;
                    lines_done_d = lines_done_q + 16'd1;
                    src_valid_d  = 1'b0;
                    snk_ready_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= RECV;
            count_q      <= '0;
            rd_idx_q     <= '0;
            data_q       <= 8'h00;
            src_valid_q  <= 1'b0;
            snk_ready_q  <= 1'b1;
            overflow_q   <= 1'b0;
            lines_done_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_idx_q     <= rd_idx_d;
            data_q       <= data_d;
            src_valid_q  <= src_valid_d;
            snk_ready_q  <= snk_ready_d;
            overflow_q   <= overflow_d;
            lines_done_q <= lines_done_d;
        end
    end

    // Buffer contents survive reset; only count decides what is valid.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            line_buf[count_q[AW-1:0]] <= serial2tcp_sink_data;
        end
    end

    assign serial2tcp_sink_ready   = snk_ready_q;
    assign serial2tcp_source_valid = src_valid_q;
    assign serial2tcp_source_data  = data_q;
    assign overflow                = overflow_q;
    assign lines_done              = lines_done_q;
endmodule

// File: tb/tb_serial2tcp_line_echo.sv
// tb/tb_serial2tcp_line_echo.sv - self-checking bench for serial2tcp_line_echo
// Directed vector table plus random lines checked against a string-level echo model.
module tb_serial2tcp_line_echo;
    localparam int DEPTH = 4;

    logic        sys_clk;
    logic        sys_rst;
    logic        sink_valid;
    logic        sink_ready;
    logic [7:0]  sink_data;
    logic        source_valid;
    logic        source_ready;
    logic [7:0]  source_data;
    logic        overflow;
    logic [15:0] lines_done;

    int checks = 0;
    int errors = 0;
    int exp_lines = 0;

    serial2tcp_line_echo #(.DEPTH(DEPTH), .TERM(8'h0A)) dut (
        .sys_clk                 (sys_clk),
        .sys_rst                 (sys_rst),
        .serial2tcp_sink_valid   (sink_valid),
        .serial2tcp_sink_ready   (sink_ready),
        .serial2tcp_sink_data    (sink_data),
        .serial2tcp_source_valid (source_valid),
        .serial2tcp_source_ready (source_ready),
        .serial2tcp_source_data  (source_data),
        .overflow                (overflow),
        .lines_done              (lines_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [63:0] in_v;
        int          in_n;
        logic [63:0] exp_v;
        int          exp_n;
        bit          ovf;
        int          pat;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        sink_valid   = 1'b1;
        sink_data    = b;
        source_ready = 1'($urandom_range(0, 1));
        while (!sink_ready && n < 100) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check("sink_ready_wait", 32'(sink_ready), 32'd1);
        @(posedge sys_clk);
        #1;
        sink_valid = 1'b0;
        sink_data  = 8'h00;
    endtask

    task automatic run_line(input logic [7:0] ib [16], input int in_n,
                            input logic [7:0] eb [16], input int en,
                            input bit eovf, input int pat);
        int  stored;
        bit  ovf_m;
        int  k;
        int  c;
        stored = 0;
        ovf_m  = 1'b0;
        for (int i = 0; i < in_n; i++) begin
            send_byte(ib[i]);
            if (i < in_n - 1) begin
                if (ib[i] != 8'h0D) begin
                    if (stored < DEPTH) stored++;
                    else ovf_m = 1'b1;
                end
                check("overflow_running", 32'(overflow), 32'(ovf_m));
                check("sink_ready_recv", 32'(sink_ready), 32'd1);
                check("source_valid_recv", 32'(source_valid), 32'd0);
            end
        end
        check("first_byte_latency", 32'(source_valid), 32'd1);
        check("overflow_at_term", 32'(overflow), 32'(eovf));
        k = 0;
        c = 0;
        while (k < en && c < 200) begin
            if (pat == 0) source_ready = 1'b1;
            else if (pat == 1) source_ready = (c % 3 == 0);
            else source_ready = 1'($urandom_range(0, 1));
            check("echo_valid", 32'(source_valid), 32'd1);
            check("echo_data", 32'(source_data), 32'(eb[k]));
            check("sink_ready_send", 32'(sink_ready), 32'd0);
            @(posedge sys_clk);
            #1;
            if (source_ready) k++;
            c++;
        end
        source_ready = 1'b0;
        check("echo_complete", 32'(k), 32'(en));
        if (pat == 0) check("echo_cycles", 32'(c), 32'(en));
        exp_lines++;
        check("sink_ready_after_lf", 32'(sink_ready), 32'd1);
        check("source_valid_after_lf", 32'(source_valid), 32'd0);
        check("overflow_cleared", 32'(overflow), 32'd0);
        check("lines_done", 32'(lines_done), 32'(exp_lines));
    endtask

    initial begin
        logic [7:0]  ib [16];
        logic [7:0]  eb [16];
        logic [63:0] lv;
        int          n;
        int          j;
        int          nz;
        logic [7:0]  v;

        sys_rst      = 1'b1;
        sink_valid   = 1'b0;
        sink_data    = 8'h00;
        source_ready = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("rst_sink_ready", 32'(sink_ready), 32'd1);
        check("rst_source_valid", 32'(source_valid), 32'd0);
        check("rst_source_data", 32'(source_data), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_lines_done", 32'(lines_done), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;

        tbl[0] = '{64'h0A4241, 3, 64'h0A0D4241, 4, 1'b0, 0};
        tbl[1] = '{64'h0A0D6968, 4, 64'h0A0D6968, 4, 1'b0, 0};
        tbl[2] = '{64'h0A, 1, 64'h0A0D, 2, 1'b0, 0};
        tbl[3] = '{64'h0A464544434241, 7, 64'h0A0D44434241, 6, 1'b1, 0};
        tbl[4] = '{64'h0A5A5958, 4, 64'h0A0D5A5958, 5, 1'b0, 1};

        for (int i = 0; i < 5; i++) begin
            for (int q = 0; q < 16; q++) begin
                ib[q] = 8'h00;
                eb[q] = 8'h00;
            end
            lv = tbl[i].in_v;
            for (int q = 0; q < 8; q++) ib[q] = lv[8*q +: 8];
            lv = tbl[i].exp_v;
            for (int q = 0; q < 8; q++) eb[q] = lv[8*q +: 8];
            run_line(ib, tbl[i].in_n, eb, tbl[i].exp_n, tbl[i].ovf, tbl[i].pat);
        end

        // Random lines: echo is the line with CRs removed, truncated to DEPTH, plus CR LF.
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(0, 9);
            for (int q = 0; q < 16; q++) begin
                ib[q] = 8'h00;
                eb[q] = 8'h00;
            end
            for (int q = 0; q < n; q++) begin
                v = 8'($urandom_range(0, 255));
                if (v == 8'h0A) v = 8'h41;
                if ($urandom_range(0, 5) == 0) v = 8'h0D;
                ib[q] = v;
            end
            ib[n] = 8'h0A;
            j  = 0;
            nz = 0;
            for (int q = 0; q < n; q++) begin
                if (ib[q] != 8'h0D) begin
                    nz++;
                    if (j < DEPTH) begin
                        eb[j] = ib[q];
                        j++;
                    end
                end
            end
            eb[j]     = 8'h0D;
            eb[j + 1] = 8'h0A;
            run_line(ib, n + 1, eb, j + 2, nz > DEPTH, 2);
        end

        // Reset while the echo is in progress.
        send_byte(8'h58);
        send_byte(8'h59);
        send_byte(8'h0A);
        source_ready = 1'b1;
        check("pre_rst_data0", 32'(source_data), 32'h58);
        @(posedge sys_clk);
        #1;
        source_ready = 1'b0;
        check("pre_rst_valid", 32'(source_valid), 32'd1);
        check("pre_rst_data1", 32'(source_data), 32'h59);
        #2;
        sys_rst = 1'b1;
        #1;
        check("midrst_source_valid", 32'(source_valid), 32'd0);
        check("midrst_sink_ready", 32'(sink_ready), 32'd1);
        check("midrst_lines_done", 32'(lines_done), 32'd0);
        check("midrst_source_data", 32'(source_data), 32'd0);
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b0;
        @(posedge sys_clk);
        #1;
        check("post_rst_source_valid", 32'(source_valid), 32'd0);
        exp_lines = 0;
        for (int q = 0; q < 16; q++) begin
            ib[q] = 8'h00;
            eb[q] = 8'h00;
        end
        ib[0] = 8'h51; ib[1] = 8'h0A;
        eb[0] = 8'h51; eb[1] = 8'h0D; eb[2] = 8'h0A;
        run_line(ib, 2, eb, 3, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
